mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Memory-side stage directly downstream of the instruction sequencer/decoder. It converts the sequencer's level-held Mem_OE/Mem_WE requests plus MAR/MDR values into timed asynchronous-SRAM cycles. It returns read data and a one-cycle Mem_Ready completion pulse. It optionally intercepts address 0xFFFF for switch input and hex-display output.

Parameters:
WAIT_CYCLES, 1, extra SRAM access cycles beyond the first (0..15); sets strobe width.
ADDR_HI, 4'h0, constant upper 4 bits of the 20-bit SRAM address.

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Mem_OE  in  1  read request, level; held by sequencer until Mem_Ready
Mem_WE  in  1  write request, level; held until Mem_Ready
ADDR  in  16  access address (MAR)
Data_from_CPU  in  16  write data (MDR)
Data_to_CPU  out  16  registered read data
Mem_Ready  out  1  one-cycle completion pulse
SW  in  16  board switches (MMIO read source)
HEX_Reg  out  16  hex-display latch (MMIO write target)
CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  SRAM strobes, active-low
SRAM_ADDR  out  20  {ADDR_HI, ADDR}
SRAM_DQ_out  out  16  write data to pad
SRAM_DQ_oe  out  1  pad driver enable
SRAM_DQ_in  in  16  read data from pad

Behaviour:
- Reset values: all *_N = 1, SRAM_DQ_oe = 0, Mem_Ready = 0, Data_to_CPU = 0, HEX_Reg = 0, SRAM_ADDR = 0, state = IDLE, counter = 0. Reset mid-access aborts immediately; strobes deassert on the following edge; no Mem_Ready is issued.
- States: IDLE, READ, WRITE, DONE, REARM.
- IDLE: on Mem_WE=1 go to WRITE. Otherwise on Mem_OE=1 go to READ. Write wins if both are high. Latch ADDR and Data_from_CPU into internal registers; load counter = WAIT_CYCLES.
- READ: CE_N=OE_N=UB_N=LB_N=0. Decrement counter. When counter==0, capture SRAM_DQ_in into Data_to_CPU and go to DONE.
- WRITE: CE_N=WE_N=UB_N=LB_N=0, SRAM_DQ_oe=1, SRAM_DQ_out = latched data. At counter==0 go to DONE.
- DONE: Mem_Ready=1 for exactly one cycle. All strobes high. SRAM_DQ_oe stays 1 this cycle after a write (data hold). Go to REARM.
- REARM: wait until Mem_OE=0 and Mem_WE=0, then go to IDLE. This prevents a held request from being serviced twice.
- Latency: request seen at edge N; Mem_Ready high in cycle N+WAIT_CYCLES+2; Data_to_CPU valid from that cycle until the next read completes.
- SRAM_ADDR and SRAM_DQ_out come from the latched registers, so they stay stable for the whole strobe even if ADDR changes.
- A request dropped before Mem_Ready still completes the access; Mem_Ready still pulses.
- WAIT_CYCLES=0 gives a single-cycle strobe.

Optional Feature:
MEM_MMIO_EN
- Defined: when latched address == 16'hFFFF, no SRAM strobe is asserted.
  - Read: Data_to_CPU <= SW in the READ first cycle; go straight to DONE.
  - Write: HEX_Reg <= latched data; go straight to DONE.
  - MMIO latency is 2 cycles regardless of WAIT_CYCLES.
- Undefined: 0xFFFF is an ordinary SRAM location, and HEX_Reg is tied to 0.

Decomposition:
- Package mem_pkg: state enum mem_state_t (IDLE, READ, WRITE, DONE, REARM), localparam MMIO_ADDR = 16'hFFFF, and SRAM address width 20.
- One natural sub-module, mem_wait_counter: loadable down-counter with a zero flag, shared by READ and WRITE.

Test Plan:
- Reset, then read at 0x0010 (SRAM holds 0x1234), WAIT_CYCLES=1 -> OE_N low 2 cycles, Mem_Ready at N+3, Data_to_CPU=0x1234.
- Write 0xBEEF to 0x0020, then read 0x0020 -> WE_N low 2 cycles with SRAM_DQ_oe=1, then read returns 0xBEEF.
- Hold Mem_OE high for 6 cycles after Mem_Ready -> exactly one SRAM access, block stays in REARM, no second Mem_Ready.
- Mem_OE=Mem_WE=1 on ADDR 0x0030 with data 0x5555 -> write performed; location reads back 0x5555.
- MEM_MMIO_EN defined, SW=0x00A5: read 0xFFFF -> 0x00A5 after 2 cycles with CE_N held 1; write 0x1357 to 0xFFFF -> HEX_Reg=0x1357.
- Assert Reset while in READ with WAIT_CYCLES=4 -> all strobes high next cycle, Mem_Ready never pulses, Data_to_CPU=0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access controller and its wait counter.
package mem_pkg;

  localparam int unsigned SRAM_AW   = 20;
  localparam int unsigned CNT_W     = 4;
  localparam logic [15:0] MMIO_ADDR = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    REARM
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag; it times the strobe width for both READ and WRITE.
module mem_wait_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns level-held Mem_OE/Mem_WE requests into timed asynchronous-SRAM cycles with a Mem_Ready pulse.
// Define MEM_MMIO_EN to map address 0xFFFF onto the switches (read) and the hex latch (write).
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [3:0]  ADDR_HI     = 4'h0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mem_OE,
  input  logic               Mem_WE,
  input  logic [15:0]        ADDR,
  input  logic [15:0]        Data_from_CPU,
  output logic [15:0]        Data_to_CPU,
  output logic               Mem_Ready,
  input  logic [15:0]        SW,
  output logic [15:0]        HEX_Reg,
  output logic               CE_N,
  output logic               OE_N,
  output logic               WE_N,
  output logic               UB_N,
  output logic               LB_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
  input  logic [15:0]        SRAM_DQ_in
);

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic [15:0] r_rdata;
  logic        r_wr;
  logic        w_zero;
  logic        w_mmio;
  logic        w_load;
  logic        w_dec;
  logic        w_finish;
  logic [15:0] w_rd_src;

  assign w_load   = (r_state == IDLE) && (Mem_OE || Mem_WE);
  assign w_dec    = (r_state == READ) || (r_state == WRITE);
  assign w_finish = w_mmio || w_zero;

  mem_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_load     (w_load),
    .i_load_val (CNT_W'(WAIT_CYCLES)),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

`ifdef MEM_MMIO_EN
  logic [15:0] r_hex;

  assign w_mmio   = (r_addr == MMIO_ADDR);
  assign w_rd_src = w_mmio ? SW : SRAM_DQ_in;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_hex <= '0;
    end else if ((r_state == WRITE) && w_mmio) begin
      r_hex <= r_data;
    end
  end

  assign HEX_Reg = r_hex;
`else
  logic w_unused;

  assign w_mmio   = 1'b0;
  assign w_rd_src = SRAM_DQ_in;
  assign HEX_Reg  = '0;
  assign w_unused = ^SW;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (Mem_WE) begin
          w_next = WRITE;
        end else if (Mem_OE) begin
          w_next = READ;
        end
      end
      READ:  if (w_finish) w_next = DONE;
      WRITE: if (w_finish) w_next = DONE;
      DONE:  w_next = REARM;
      REARM: if (!Mem_OE && !Mem_WE) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    CE_N       = 1'b1;
    OE_N       = 1'b1;
    WE_N       = 1'b1;
    UB_N       = 1'b1;
    LB_N       = 1'b1;
    SRAM_DQ_oe = 1'b0;
    Mem_Ready  = 1'b0;
    unique case (r_state)
      READ: begin
        if (!w_mmio) begin
          CE_N = 1'b0;
          OE_N = 1'b0;
          UB_N = 1'b0;
          LB_N = 1'b0;
        end
      end
      WRITE: begin
        if (!w_mmio) begin
          CE_N       = 1'b0;
          WE_N       = 1'b0;
          UB_N       = 1'b0;
          LB_N       = 1'b0;
          SRAM_DQ_oe = 1'b1;
        end
      end
      DONE: begin
        Mem_Ready  = 1'b1;
        // Keep driving the pad one cycle past WE_N rising for data hold.
        SRAM_DQ_oe = r_wr && !w_mmio;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_load) begin
        r_addr <= ADDR;
        r_data <= Data_from_CPU;
        r_wr   <= Mem_WE;
      end
      if ((r_state == READ) && w_finish) begin
        r_rdata <= w_rd_src;
      end
    end
  end

  assign Data_to_CPU = r_rdata;
  assign SRAM_ADDR   = {ADDR_HI, r_addr};
  assign SRAM_DQ_out = r_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed plus randomized bench for mem_access_ctrl against a behavioural memory reference.
module tb_mem_access_ctrl;

  localparam int unsigned WAIT = 1;
  localparam logic [3:0]  AHI  = 4'h0;

  logic        Clk;
  logic        Reset;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_from_CPU;
  logic [15:0] Data_to_CPU;
  logic        Mem_Ready;
  logic [15:0] SW;
  logic [15:0] HEX_Reg;
  logic        CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic [15:0] SRAM_DQ_in;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mem_access_ctrl #(
    .WAIT_CYCLES (WAIT),
    .ADDR_HI     (AHI)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Mem_Ready     (Mem_Ready),
    .SW            (SW),
    .HEX_Reg       (HEX_Reg),
    .CE_N          (CE_N),
    .OE_N          (OE_N),
    .WE_N          (WE_N),
    .UB_N          (UB_N),
    .LB_N          (LB_N),
    .SRAM_ADDR     (SRAM_ADDR),
    .SRAM_DQ_out   (SRAM_DQ_out),
    .SRAM_DQ_oe    (SRAM_DQ_oe),
    .SRAM_DQ_in    (SRAM_DQ_in)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Power-up contents of the SRAM part.
  function automatic logic [15:0] init_pat(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction

  // SRAM device: stored as a delta from the power-up pattern so untouched cells read init_pat.
  bit [15:0] sram_delta [0:65535];
  always @(posedge Clk) begin
    if (!CE_N && !WE_N) sram_delta[SRAM_ADDR[15:0]] <= SRAM_DQ_out ^ init_pat(SRAM_ADDR[15:0]);
  end
  assign SRAM_DQ_in = (!CE_N && !OE_N) ? (sram_delta[SRAM_ADDR[15:0]] ^ init_pat(SRAM_ADDR[15:0]))
                                       : 16'hDEAD;

  // Reference model: architectural memory contents and the hex latch.
  logic [15:0] ref_mem [int];
  logic [15:0] exp_hex = '0;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic wr, input logic rd_too, input logic [15:0] a,
                        input logic [15:0] d, input int unsigned hold);
    int unsigned k, n_ce, n_oe, n_we, lat, slen;
    logic        seen, mmio;
    logic [15:0] exp_rd;
    mmio = 1'b0;
`ifdef MEM_MMIO_EN
    mmio = (a == 16'hFFFF);
`endif
    lat  = mmio ? 2 : WAIT + 2;
    slen = mmio ? 0 : WAIT + 1;
    @(negedge Clk);
    ADDR = a; Data_from_CPU = d; Mem_WE = wr; Mem_OE = !wr || rd_too;
    k = 0; n_ce = 0; n_oe = 0; n_we = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge Clk);
      k++;
      ADDR = 16'($urandom);
      Data_from_CPU = 16'($urandom);
      if (!CE_N) n_ce++;
      if (!OE_N) begin
        n_oe++;
        check("rd_addr", 32'(SRAM_ADDR), 32'({AHI, a}));
      end
      if (!WE_N) begin
        n_we++;
        check("wr_oe", 32'(SRAM_DQ_oe), 32'd1);
        check("wr_data", 32'(SRAM_DQ_out), 32'(d));
        check("wr_addr", 32'(SRAM_ADDR), 32'({AHI, a}));
      end
      if (Mem_Ready) seen = 1'b1;
    end
    check("ready_seen", 32'(seen), 32'd1);
    check("latency", k, lat);
    check("ce_cycles", n_ce, slen);
    check("oe_cycles", n_oe, wr ? 0 : slen);
    check("we_cycles", n_we, wr ? slen : 0);
    if (wr) begin
      if (mmio) exp_hex = d;
      else begin
        ref_mem[int'(a)] = d;
        check("dq_hold", 32'(SRAM_DQ_oe), 32'd1);
      end
      exp_rd = 16'h0;
    end else begin
      exp_rd = mmio ? SW : ref_read(a);
      check("rdata", 32'(Data_to_CPU), 32'(exp_rd));
    end
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge Clk);
      check("hold_ready", 32'(Mem_Ready), 32'd0);
      check("hold_ce", 32'(CE_N), 32'd1);
    end
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    @(negedge Clk);
    check("ready_pulse", 32'(Mem_Ready), 32'd0);
    check("oe_release", 32'(SRAM_DQ_oe), 32'd0);
    check("hex", 32'(HEX_Reg), 32'(exp_hex));
    if (!wr) check("rdata_hold", 32'(Data_to_CPU), 32'(exp_rd));
    @(negedge Clk);
  endtask

  initial begin
    logic [15:0] ra, rd;
    logic        rw;
    Reset = 1'b1; Mem_OE = 1'b0; Mem_WE = 1'b0;
    ADDR = '0; Data_from_CPU = '0; SW = 16'h00A5;
    repeat (3) @(negedge Clk);
    check("rst_strobes", 32'({CE_N, OE_N, WE_N, UB_N, LB_N}), 32'h1F);
    check("rst_dq_oe", 32'(SRAM_DQ_oe), 32'd0);
    check("rst_ready", 32'(Mem_Ready), 32'd0);
    check("rst_data", 32'(Data_to_CPU), 32'd0);
    check("rst_hex", 32'(HEX_Reg), 32'd0);
    check("rst_addr", 32'(SRAM_ADDR), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    access(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    access(1'b1, 1'b0, 16'h0020, 16'hBEEF, 0);
    access(1'b0, 1'b0, 16'h0020, 16'h0000, 0);
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 6);
    access(1'b1, 1'b1, 16'h0030, 16'h5555, 0);
    access(1'b0, 1'b0, 16'h0030, 16'h0000, 0);
    access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 0);
    access(1'b1, 1'b0, 16'hFFFF, 16'h1357, 0);
    access(1'b0, 1'b0, 16'hFFFF, 16'h0000, 0);

    for (int n = 0; n < 24; n++) begin
      ra = 16'h0100 + 16'($urandom_range(0, 15));
      rd = 16'($urandom);
      rw = 1'($urandom_range(0, 1));
      access(rw, 1'b0, ra, rd, 0);
    end

    access(1'b0, 1'b0, 16'h0010, 16'h0000, 0);
    @(negedge Clk);
    ADDR = 16'h0040; Mem_OE = 1'b1;
    @(negedge Clk);
    check("pre_rst_oe", 32'(OE_N), 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_strobes", 32'({CE_N, OE_N, WE_N, UB_N, LB_N}), 32'h1F);
    check("abort_ready", 32'(Mem_Ready), 32'd0);
    check("abort_data", 32'(Data_to_CPU), 32'd0);
    Reset = 1'b0; Mem_OE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("abort_no_ready", 32'(Mem_Ready), 32'd0);
    end
    access(1'b0, 1'b0, 16'h0020, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
